// File: rtl/instruction_decoder_pkg.sv
// instruction_decoder_pkg: default widths, opcode enum, buffer states and the decoded-entry struct
package instruction_decoder_pkg;
  localparam int DEF_INSTRUCTION_WIDTH = 20;
  localparam int DEF_TYPE_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = DEF_INSTRUCTION_WIDTH - DEF_TYPE_WIDTH;
  localparam int DEF_PC_WIDTH = 9;
  localparam int DEF_NUM_OPCODES = 10;
  typedef enum logic [DEF_TYPE_WIDTH-1:0] {
    ACCEPT = 0, SPLIT, MATCH, JMP, END_WITHOUT_ACCEPTING,
    MATCH_ANY, ACCEPT_PARTIAL, NOT_MATCH, MATCH_RANGE, NOT_MATCH_RANGE = 9
  } opcode_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;
  typedef struct packed {
    logic [DEF_TYPE_WIDTH-1:0] typ;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_PC_WIDTH-1:0] pc;
    logic [DEF_NUM_OPCODES-1:0] onehot;
    logic [DEF_DATA_WIDTH/2-1:0] lo;
    logic [DEF_DATA_WIDTH/2-1:0] hi;
    logic illegal;
  } decoded_t;
endpackage

// File: rtl/instruction_field_decode.sv
// instruction_field_decode: word (instr_i) -> onehot_o, ordered range_lo_o/range_hi_o, illegal_o
module instruction_field_decode
  import instruction_decoder_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int TYPE_WIDTH = DEF_TYPE_WIDTH,
  parameter int NUM_OPCODES = DEF_NUM_OPCODES,
  localparam int DW = INSTRUCTION_WIDTH - TYPE_WIDTH,
  localparam int HW = DW / 2
) (
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  output logic [NUM_OPCODES-1:0] onehot_o,
  output logic [HW-1:0] range_lo_o,
  output logic [HW-1:0] range_hi_o,
  output logic illegal_o
);
  logic [TYPE_WIDTH-1:0] typ;
  logic [HW-1:0] lo_raw, hi_raw;
  assign typ = instr_i[INSTRUCTION_WIDTH-1 -: TYPE_WIDTH];
  assign lo_raw = instr_i[HW-1:0];
  assign hi_raw = instr_i[DW-1:HW];
  assign illegal_o = 32'(typ) >= NUM_OPCODES;
  assign onehot_o = illegal_o ? '0 : NUM_OPCODES'(1) << typ;
  assign range_lo_o = lo_raw > hi_raw ? hi_raw : lo_raw;
  assign range_hi_o = lo_raw > hi_raw ? lo_raw : hi_raw;
endmodule

// File: rtl/instruction_decoder.sv
// instruction_decoder: 2-entry skid-buffered decoder; in_valid/in_ready/in_instr/in_pc in, out_* decoded entry out, flush, illegal_count
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int TYPE_WIDTH = DEF_TYPE_WIDTH,
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int NUM_OPCODES = DEF_NUM_OPCODES,
  localparam int DATA_WIDTH = INSTRUCTION_WIDTH - TYPE_WIDTH,
  localparam int HW = DATA_WIDTH / 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic out_valid,
  input  logic out_ready,
  output logic [TYPE_WIDTH-1:0] out_type,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [NUM_OPCODES-1:0] out_onehot,
  output logic [HW-1:0] out_range_lo,
  output logic [HW-1:0] out_range_hi,
  output logic out_illegal,
  output logic [7:0] illegal_count
);
  if (DATA_WIDTH % 2 != 0) begin : g_odd_data
    $error("DATA_WIDTH must be even");
  end
  typedef struct packed {
    logic [TYPE_WIDTH-1:0] typ;
    logic [DATA_WIDTH-1:0] data;
    logic [PC_WIDTH-1:0] pc;
    logic [NUM_OPCODES-1:0] onehot;
    logic [HW-1:0] lo;
    logic [HW-1:0] hi;
    logic illegal;
  } entry_t;
  buf_state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, new_e;
  logic [7:0] cnt_q, cnt_d;
  logic in_ready_q, in_ready_d, acc, drn;
  assign new_e.typ = in_instr[INSTRUCTION_WIDTH-1 -: TYPE_WIDTH];
  assign new_e.data = in_instr[DATA_WIDTH-1:0];
  assign new_e.pc = in_pc;
  instruction_field_decode #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH),
    .TYPE_WIDTH(TYPE_WIDTH),
    .NUM_OPCODES(NUM_OPCODES)
  ) u_dec (
    .instr_i(in_instr),
    .onehot_o(new_e.onehot),
    .range_lo_o(new_e.lo),
    .range_hi_o(new_e.hi),
    .illegal_o(new_e.illegal)
  );
  assign acc = in_valid && in_ready_q;
  assign drn = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    cnt_d = cnt_q;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (acc) begin state_d = ONE; main_d = new_e; end
        ONE: if (acc && drn) main_d = new_e;
             else if (acc) begin state_d = FULL; skid_d = new_e; end
             else if (drn) state_d = EMPTY;
        FULL: if (drn) begin state_d = ONE; main_d = skid_q; end
        default: state_d = EMPTY;
      endcase
      cnt_d = acc && new_e.illegal && cnt_q != 8'hFF ? cnt_q + 8'd1 : cnt_q;
    end
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign out_type = main_q.typ;
  assign out_data = main_q.data;
  assign out_pc = main_q.pc;
  assign out_onehot = main_q.onehot;
  assign out_range_lo = main_q.lo;
  assign out_range_hi = main_q.hi;
  assign out_illegal = main_q.illegal;
  assign illegal_count = cnt_q;
endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 20, total instruction bits.
REQ-002 SHALL have parameter TYPE_WIDTH, default 4, opcode field width in MSBs; DATA_WIDTH = INSTRUCTION_WIDTH-TYPE_WIDTH.
REQ-003 SHALL have parameter PC_WIDTH, default 9, program-counter width.
REQ-004 SHALL have parameter NUM_OPCODES, default 10, count of legal opcode encodings 0..NUM_OPCODES-1.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-007 flush  input  1  synchronous discard of all buffered entries.
REQ-008 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-009 in_instr  input  INSTRUCTION_WIDTH  raw instruction word.
REQ-010 in_pc  input  PC_WIDTH  address of in_instr.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-012 out_type  output  TYPE_WIDTH  opcode field.
REQ-013 out_data  output  DATA_WIDTH  data field, unmodified.
REQ-014 out_pc  output  PC_WIDTH  PC of decoded entry.
REQ-015 out_onehot  output  NUM_OPCODES  bit k set iff out_type==k.
REQ-016 out_range_lo / out_range_hi  output  DATA_WIDTH/2 each  normalised range bounds.
REQ-017 out_illegal  output  1  out_type >= NUM_OPCODES.
REQ-018 illegal_count  output  8  saturating count of illegal instructions accepted.

Function
REQ-019 Transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-020 Latency SHALL be exactly 1 cycle: a word accepted at edge N is presented on out_* after edge N when buffer was empty.
REQ-021 Storage SHALL be a 2-entry skid buffer (main + skid register); in_ready SHALL be registered and equal "skid entry empty".
REQ-022 Buffer states SHALL be EMPTY, ONE (main valid), FULL (main+skid valid); EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE->FULL on accept while out_ready=0; FULL->ONE on drain; ONE stays ONE on simultaneous accept+drain.
REQ-023 In FULL, on drain the skid entry SHALL move to main in the same edge, order preserved.
REQ-024 Decode (onehot, range, illegal) SHALL be computed at accept and stored with the entry, not recomputed at output.
REQ-025 Range split: lo_raw = data[DATA_WIDTH/2-1:0], hi_raw = data[DATA_WIDTH-1:DATA_WIDTH/2]; if lo_raw > hi_raw (unsigned) outputs SHALL be swapped so out_range_lo <= out_range_hi; DATA_WIDTH odd SHALL be rejected at elaboration.
REQ-026 out_onehot SHALL be all zero when out_illegal=1.
REQ-027 illegal_count SHALL increment by 1 per accepted illegal word and hold at 255.
REQ-028 out_* data SHALL stay stable while out_valid && !out_ready.
REQ-029 flush SHALL take priority: next state EMPTY, in_ready=1, any same-cycle in_valid word is dropped and not counted; illegal_count unaffected.
REQ-030 When out_valid=0, out_* data values are don't-care but SHALL not be X after reset.

Reset
REQ-031 On rst_n low (asynchronous, any time incl. mid-transfer): state EMPTY, out_valid=0, in_ready=1, all out_* data registers 0, illegal_count=0.
REQ-032 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package SHALL hold INSTRUCTION_WIDTH, TYPE_WIDTH, DATA_WIDTH defaults, the opcode enum (ACCEPT=0, SPLIT, MATCH, JMP, END_WITHOUT_ACCEPTING, MATCH_ANY, ACCEPT_PARTIAL, NOT_MATCH, MATCH_RANGE, NOT_MATCH_RANGE=9) and the decoded-entry packed struct.
REQ-034 A combinational sub-module instruction_field_decode (word -> onehot, range, illegal) SHALL be instantiated once at the input side.

Verification
REQ-035 Stream 0x2_0041 (MATCH 'A') at pc 3 with out_ready=1 -> next cycle out_type=2, out_onehot=0x004, out_data=0x0041, out_pc=3.
REQ-036 MATCH_RANGE 0x8_7A61 -> out_range_lo=0x61, out_range_hi=0x7A; 0x8_617A -> lo=0x61, hi=0x7A (swapped).
REQ-037 Back-pressure: out_ready=0, push 3 words -> first two accepted, in_ready=0 after second, third held; release -> order w0,w1,w2, no loss/duplication.
REQ-038 Opcodes 0xA..0xF x300 -> out_illegal=1, out_onehot=0, illegal_count saturates at 255.
REQ-039 flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped word never appears.
REQ-040 rst_n asserted mid-burst asynchronously -> outputs at reset values before next edge; resumed stream decodes correctly.
